// File: rtl/fsd1_telemetry_decoder_if.sv
// rtl/fsd1_telemetry_decoder_if.sv - RX8 byte handshake into the telemetry decoder
interface fsd1_telemetry_decoder_if;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (output rx_data, output rx_ready);
  modport slave  (input  rx_data, input  rx_ready);
endinterface

// File: rtl/fsd1_telemetry_decoder.sv
// rtl/fsd1_telemetry_decoder.sv - parses FSd1 ASCII measurement lines into binary counters
module fsd1_telemetry_decoder #(
  parameter int RAW_DIGITS  = 4,
  parameter int SIG_DIGITS  = 6,
  parameter int TIMEOUT_CYC = 24000,
  parameter int ERRCNT_W    = 8
) (
  input  logic                    clk24M,
  input  logic                    rst_n,
  fsd1_telemetry_decoder_if.slave rx,
  output logic [4*RAW_DIGITS-1:0] raw0,
  output logic [4*RAW_DIGITS-1:0] raw1,
  output logic [4*RAW_DIGITS-1:0] raw2,
  output logic [4*SIG_DIGITS-1:0] sig0,
  output logic [4*SIG_DIGITS-1:0] sig1,
  output logic [4*SIG_DIGITS-1:0] sig2,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic                    synced,
  output logic [ERRCNT_W-1:0]     err_count
);

  localparam int RAW_W = 4 * RAW_DIGITS;
  localparam int SIG_W = 4 * SIG_DIGITS;
  localparam int MAXD  = (RAW_DIGITS > SIG_DIGITS) ? RAW_DIGITS : SIG_DIGITS;
  localparam int ACC_W = 4 * MAXD;
  localparam int CW    = $clog2(MAXD + 1);
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_COMMA = 8'h2C;

  typedef enum logic [1:0] {S_SYNC, S_FIELD, S_EXPECT_LF} state_t;

  state_t             state, next_state;
  logic               ready_p;
  logic               ev;
  logic               is_digit;
  logic [3:0]         nibble;
  logic [ACC_W-1:0]   acc;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      exp_cnt;
  logic [2:0]         field;
  logic [RAW_W-1:0]   sh_raw [3];
  logic [SIG_W-1:0]   sh_sig [3];
  logic [TW-1:0]      tmr;
  logic               running;
  logic               timeout;
  logic               do_shift, do_store, do_commit, do_clear, do_err;

  assign ev      = rx.rx_ready & ~ready_p;
  assign exp_cnt = (field < 3'd3) ? CW'(RAW_DIGITS) : CW'(SIG_DIGITS);
  assign synced  = (state == S_FIELD) || (state == S_EXPECT_LF);
  // Idle gap between lines (FIELD with nothing received yet) is not timed.
  assign running = (state == S_EXPECT_LF) ||
                   ((state == S_FIELD) && !((field == 3'd0) && (cnt == '0)));
  assign timeout = running && !ev && (tmr == TW'(TIMEOUT_CYC - 1));

  // Hex digit decode of the incoming byte, both letter cases.
  always_comb begin
    is_digit = 1'b0;
    nibble   = 4'd0;
    if (rx.rx_data >= 8'h30 && rx.rx_data <= 8'h39) begin
      is_digit = 1'b1;
      nibble   = rx.rx_data[3:0];
    end else if ((rx.rx_data >= 8'h41 && rx.rx_data <= 8'h46) ||
                 (rx.rx_data >= 8'h61 && rx.rx_data <= 8'h66)) begin
      is_digit = 1'b1;
      nibble   = rx.rx_data[3:0] + 4'd9;
    end
  end

  // Line parser next-state and datapath controls; a byte event always beats a timeout.
  always_comb begin
    next_state = state;
    do_shift   = 1'b0;
    do_store   = 1'b0;
    do_commit  = 1'b0;
    do_clear   = 1'b0;
    do_err     = 1'b0;
    case (state)
      S_SYNC: begin
        if (ev && rx.rx_data == CH_LF) begin
          do_clear   = 1'b1;
          next_state = S_FIELD;
        end
      end
      S_FIELD: begin
        if (ev) begin
          if (is_digit && cnt < exp_cnt) begin
            do_shift = 1'b1;
          end else if (rx.rx_data == CH_COMMA && field < 3'd5 && cnt == exp_cnt) begin
            do_store = 1'b1;
          end else if (rx.rx_data == CH_CR && field == 3'd5 && cnt == exp_cnt) begin
            do_store   = 1'b1;
            next_state = S_EXPECT_LF;
          end else if (rx.rx_data == CH_LF) begin
            do_err     = 1'b1;
            do_clear   = 1'b1;
            next_state = S_FIELD;
          end else begin
            do_err     = 1'b1;
            next_state = S_SYNC;
          end
        end else if (timeout) begin
          do_err     = 1'b1;
          next_state = S_SYNC;
        end
      end
      S_EXPECT_LF: begin
        if (ev) begin
          if (rx.rx_data == CH_LF) begin
            do_commit  = 1'b1;
            do_clear   = 1'b1;
            next_state = S_FIELD;
          end else begin
            do_err     = 1'b1;
            next_state = S_SYNC;
          end
        end else if (timeout) begin
          do_err     = 1'b1;
          next_state = S_SYNC;
        end
      end
      default: next_state = S_SYNC;
    endcase
  end

  // Parser state register.
  always_ff @(posedge clk24M or negedge rst_n) begin
    if (!rst_n) state <= S_SYNC;
    else        state <= next_state;
  end

  // Byte strobe, working accumulator, shadows, timeout and committed outputs.
  always_ff @(posedge clk24M or negedge rst_n) begin
    if (!rst_n) begin
      ready_p     <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      field       <= '0;
      tmr         <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
      raw0 <= '0; raw1 <= '0; raw2 <= '0;
      sig0 <= '0; sig1 <= '0; sig2 <= '0;
      for (int i = 0; i < 3; i++) begin
        sh_raw[i] <= '0;
        sh_sig[i] <= '0;
      end
    end else begin
      ready_p     <= rx.rx_ready;
      frame_valid <= do_commit;
      frame_err   <= do_err;
      if (do_err && err_count != '1) err_count <= err_count + 1'b1;
      if (ev || !running) tmr <= '0;
      else                tmr <= tmr + 1'b1;
      if (do_clear) begin
        acc   <= '0;
        cnt   <= '0;
        field <= '0;
      end else if (do_shift) begin
        acc <= {acc[ACC_W-5:0], nibble};
        cnt <= cnt + 1'b1;
      end else if (do_store) begin
        for (int i = 0; i < 3; i++) begin
          if (field == 3'(i))     sh_raw[i] <= acc[RAW_W-1:0];
          if (field == 3'(i + 3)) sh_sig[i] <= acc[SIG_W-1:0];
        end
        field <= field + 1'b1;
        acc   <= '0;
        cnt   <= '0;
      end
      if (do_commit) begin
        raw0 <= sh_raw[0]; raw1 <= sh_raw[1]; raw2 <= sh_raw[2];
        sig0 <= sh_sig[0]; sig1 <= sh_sig[1]; sig2 <= sh_sig[2];
      end
    end
  end

endmodule

// File: doc/fsd1_telemetry_decoder.md
Name: fsd1_telemetry_decoder

Overview:
- Parses the ASCII measurement line that FSd1 sends over UART back into binary counter values.
- Line format, in order: raw0, raw1, raw2 as 4-digit hex; then sig0, sig1, sig2 as 6-digit hex; fields separated by ','; line terminated by CR LF.
- Sits behind an RX8 byte receiver, in the loopback and self-test build or on a companion board.
- Commits a complete validated frame atomically. Flags malformed frames and resynchronises on the next LF.

Parameters:
- RAW_DIGITS, 4, number of hex digits per raw field (raw output width = 4*RAW_DIGITS).
- SIG_DIGITS, 6, number of hex digits per sig field (sig output width = 4*SIG_DIGITS).
- TIMEOUT_CYC, 24000, idle clk24M cycles allowed between bytes inside a frame before the frame is abandoned.
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk24M  in  1  system clock, 24 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_data  in  8  byte from RX8; stable while rx_ready is high.
- rx_ready  in  1  RX8 ready level. A byte is consumed on its 0->1 edge.
- raw0, raw1, raw2  out  4*RAW_DIGITS each  last committed raw counts.
- sig0, sig1, sig2  out  4*SIG_DIGITS each  last committed signal counts.
- frame_valid  out  1  one-cycle pulse when a frame commits.
- frame_err  out  1  one-cycle pulse when a frame is rejected.
- synced  out  1  high while in FIELD or EXPECT_LF.
- err_count  out  ERRCNT_W  rejected frames, saturating.

Behaviour:
- Reset values: all data outputs 0; frame_valid, frame_err and err_count 0; synced 0; state SYNC.
- Byte strobe: ready_p registers rx_ready. A byte event is rx_ready & ~ready_p. At most one event per cycle. A level held high produces exactly one event.
- Digit decode: '0'-'9', 'A'-'F' and 'a'-'f' are hex digits. Every other byte is a non-digit.
- Working state: a 24-bit shift accumulator, a digit counter, a field index 0..5, and six shadow registers. Each digit does acc <= {acc, nibble} (shift left 4, insert nibble).
- State SYNC: discard every byte except LF (0x0A). On LF, clear the working state and go to FIELD.
- State FIELD: expected digit count is RAW_DIGITS for fields 0-2 and SIG_DIGITS for fields 3-5.
  - Digit while count < expected: shift it in, count+1.
  - ',' while field < 5 and count == expected: store acc into shadow[field], field+1, count and acc cleared.
  - CR while field == 5 and count == expected: store shadow[5], go to EXPECT_LF.
  - Any other byte, including an extra digit, a wrong separator, or an early or late CR: error.
- State EXPECT_LF:
  - LF: copy all six shadows to the outputs in the same edge, pulse frame_valid, clear working state, stay synced in FIELD.
  - Any other byte: error.
- Latency: outputs and frame_valid update on the cycle after the byte event of the final LF.
- Error handling: pulse frame_err; err_count+1, saturating at all-ones; go to SYNC. Outputs keep the last committed frame.
  - Exception: an LF received in FIELD is an error, but the block goes directly to FIELD with working state cleared. That LF acts as the resync point.
- Timeout: a counter reloads on every byte event and runs only in FIELD or EXPECT_LF.
  - It is not counted in FIELD while field==0 and count==0, the idle wait between lines.
  - Reaching TIMEOUT_CYC is an error, goes to SYNC, and increments err_count.
- Simultaneous events: a timeout expiry and a byte event in the same cycle resolve in favour of the byte; the timeout is ignored.
- Reset mid-frame: working state and outputs are cleared immediately. The block must see an LF before accepting data again.

Test Plan:
- Reset, send LF then "0064,00C8,012C,000190,0001F4,000258\r\n" -> one frame_valid pulse; raw0=0x0064, raw1=0x00C8, raw2=0x012C, sig0=0x000190, sig1=0x0001F4, sig2=0x000258; err_count=0.
- Without a leading LF, send one full valid line, then a second valid line with raw0="00ff" -> first line discarded with no pulses; second line commits raw0=0x00FF (lowercase accepted); synced rises after the first LF.
- Committed frame, then "0064,00C8,01G4,..." -> frame_err pulse at 'G'; err_count=1; outputs unchanged; resyncs on the next LF and accepts the following valid line.
- Field with 5 digits "00064," and a line with CR after field 4 -> each gives frame_err and increments err_count; no frame_valid.
- Stop mid-field for TIMEOUT_CYC cycles -> frame_err and SYNC state. Also hold rx_ready high for 10 cycles on one byte -> consumed once.
- Inject 300 bad frames -> err_count saturates at 255. Assert rst_n low mid-frame -> all outputs 0 and synced 0 asynchronously.
